// File: rtl/regfile_pkg.sv
//------------------------------------------------------------------------------
// Module : regfile_pkg
// Purpose: Shared defaults and types for the scoreboarded register file.
//          Holds the default data width and register count, plus the
//          register-address and data-word types for the default configuration.
// Ports  : none (package)
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int NREGS_DEF   = 32;
  localparam int RADDR_W_DEF = $clog2(NREGS_DEF);

  typedef logic [RADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0]    word_t;

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
//------------------------------------------------------------------------------
// Module : rf_scoreboard
// Purpose: Per-register busy tracking for the register file. An issue marks its
//          destination busy; a write clears it. A registered count of busy
//          registers is maintained alongside.
// Ports  : clk, rst          clock, async active-high reset
//          rd_addr/rd_busy   per read port: busy status of the addressed reg
//          wr_en/wr_addr     two write ports (clear busy)
//          iss_en/iss_addr   issue strobe (set busy)
//          busy_cnt          number of busy registers
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NRP    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRP-1:0][AW-1:0]  rd_addr,
  output logic [NRP-1:0]          rd_busy,
  input  logic [1:0]              wr_en,
  input  logic [1:0][AW-1:0]      wr_addr,
  input  logic                    iss_en,
  input  logic [AW-1:0]           iss_addr,
  output logic [AW:0]             busy_cnt
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] iss_hit;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;

  // One-hot decode of this cycle's writes and issue; register 0 never tracks.
  always_comb begin
    wr_hit  = '0;
    iss_hit = '0;
    for (int k = 0; k < 2; k++) begin
      if (wr_en[k]) wr_hit[wr_addr[k]] = 1'b1;
    end
    if (iss_en) iss_hit[iss_addr] = 1'b1;
    wr_hit[0]  = 1'b0;
    iss_hit[0] = 1'b0;
  end

  // Issue is applied after the clear: a same-cycle issue is the newer producer.
  assign busy_d = (busy_q & ~wr_hit) | iss_hit;

  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // With forwarding, a register being cleared this cycle already reads not-busy
  // unless an issue re-targets it in the same cycle.
  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NRP; i++) begin
      rd_busy[i] = busy_q[rd_addr[i]];
      if (BYPASS != 0) begin
        rd_busy[i] = busy_q[rd_addr[i]] &
                     ~(wr_hit[rd_addr[i]] & ~iss_hit[rd_addr[i]]);
      end
    end
  end

  assign busy_cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
//------------------------------------------------------------------------------
// Module : regfile_sb
// Purpose: Multi-read, dual-write register file with optional same-cycle
//          write-to-read forwarding and a busy-bit scoreboard. Register 0 is
//          hard-wired to zero. Write port 1 wins on address collisions.
// Ports  : clk, rst          clock, async active-high reset
//          rd_addr/rd_data   NRP combinational read ports
//          rd_busy           busy status of each read port's register
//          wr_en/wr_addr/wr_data  two write ports
//          iss_en/iss_addr   issue strobe marking a destination busy
//          busy_cnt          registered count of busy registers
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRP    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRP-1:0][AW-1:0]   rd_addr,
  output logic [NRP-1:0][XLEN-1:0] rd_data,
  output logic [NRP-1:0]           rd_busy,
  input  logic [1:0]               wr_en,
  input  logic [1:0][AW-1:0]       wr_addr,
  input  logic [1:0][XLEN-1:0]     wr_data,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
  output logic [AW:0]              busy_cnt
);

  // Storage for registers 1..NREGS-1 only; register 0 is a constant.
  logic [XLEN-1:0] mem_q [1:NREGS-1];
  logic [XLEN-1:0] mem_d [1:NREGS-1];
  logic [XLEN-1:0] rf_w  [NREGS];

  // Port 1 is evaluated last so it overrides port 0 on a collision.
  always_comb begin
    for (int r = 1; r < NREGS; r++) begin
      mem_d[r] = mem_q[r];
      if (wr_en[0] && (wr_addr[0] == AW'(r))) mem_d[r] = wr_data[0];
      if (wr_en[1] && (wr_addr[1] == AW'(r))) mem_d[r] = wr_data[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NREGS; r++) mem_q[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) mem_q[r] <= mem_d[r];
    end
  end

  always_comb begin
    rf_w[0] = '0;
    for (int r = 1; r < NREGS; r++) rf_w[r] = mem_q[r];
  end

  // Forwarding is suppressed during reset so reads stay zero even while the
  // write ports are active.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRP; i++) begin
      rd_data[i] = rf_w[rd_addr[i]];
      if ((BYPASS != 0) && !rst && (rd_addr[i] != '0)) begin
        if (wr_en[0] && (wr_addr[0] == rd_addr[i])) rd_data[i] = wr_data[0];
        if (wr_en[1] && (wr_addr[1] == rd_addr[i])) rd_data[i] = wr_data[1];
      end
    end
  end

  rf_scoreboard #(
    .NREGS  (NREGS),
    .NRP    (NRP),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_cnt (busy_cnt)
  );

endmodule

`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width in bits.
REQ-002 SHALL provide parameter NREGS, default 32, number of architectural registers (power of 2, 2..64).
REQ-003 SHALL provide parameter NRP, default 2, number of read ports (1..4).
REQ-004 SHALL provide parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 rd_addr  input  NRP x log2(NREGS)  read-port addresses.
REQ-009 rd_data  output  NRP x XLEN  read-port data.
REQ-010 rd_busy  output  NRP  register at rd_addr[i] has an outstanding producer.
REQ-011 wr_en  input  2  write-port enables; port 1 is the higher-priority port.
REQ-012 wr_addr  input  2 x log2(NREGS)  write addresses.
REQ-013 wr_data  input  2 x XLEN  write data.
REQ-014 iss_en  input  1  issue strobe; marks iss_addr busy.
REQ-015 iss_addr  input  log2(NREGS)  destination register of the issued instruction.
REQ-016 busy_cnt  output  log2(NREGS)+1  number of registers currently busy.

Function
REQ-017 Reads SHALL be combinational; register 0 SHALL always read 0 and SHALL never be busy.
REQ-018 Writes SHALL commit on the rising clk edge when wr_en[k]=1 and wr_addr[k]!=0; writes to address 0 SHALL be discarded.
REQ-019 Two enabled writes to the same address SHALL commit port 1's data only.
REQ-020 With BYPASS=1, a read to a nonzero address written in the same cycle SHALL return the winning wr_data; with BYPASS=0, it SHALL return the stored value.
REQ-021 Each register SHALL hold a busy bit: iss_en sets bit iss_addr, and an enabled write clears bit wr_addr, both on the clock edge.
REQ-022 When issue and write target the same register in the same cycle, the busy bit SHALL end up set, because the issue is the newer producer.
REQ-023 A write to a non-busy register SHALL still update data and SHALL leave busy clear.
REQ-024 rd_busy[i] SHALL reflect the registered busy bit; with BYPASS=1, it SHALL read 0 when a same-cycle write clears that register and no same-cycle issue targets it.
REQ-025 iss_en to an already-busy register SHALL keep it busy and SHALL leave busy_cnt unchanged.
REQ-026 busy_cnt SHALL be registered and SHALL equal the population count of the busy bits after each edge, ranging 0..NREGS-1.

Reset
REQ-027 Asserting rst SHALL immediately clear all data registers to 0, all busy bits to 0 and busy_cnt to 0, regardless of clk.
REQ-028 While rst is high, writes and issues SHALL be ignored; during reset rd_data SHALL read 0 and rd_busy SHALL read 0.
REQ-029 The first edge after rst deasserts SHALL process writes and issues normally.

Structure
REQ-030 XLEN and NREGS defaults, the register-address typedef and the data-word typedef SHALL live in shared package regfile_pkg.
REQ-031 Busy-bit tracking and busy_cnt SHALL be a sub-module, rf_scoreboard; data storage and bypass SHALL stay in regfile_sb.

Verification
REQ-032 Reset, then write x5=0xDEADBEEF -> next cycle, reading rd_addr=5 SHALL return 0xDEADBEEF.
REQ-033 Both ports write x7 in one cycle (port0 0x11, port1 0x22) -> x7 SHALL read 0x22; writing x0=0xFFFF_FFFF -> x0 SHALL read 0.
REQ-034 With BYPASS=1, write x3=0xA5 while reading x3 in the same cycle -> rd_data SHALL be 0xA5 that cycle; with BYPASS=0, it SHALL be the old value.
REQ-035 Issue x4, then x9 -> busy_cnt SHALL be 2; write x4 -> rd_busy for x4 SHALL be 0 and busy_cnt SHALL be 1; issue and write x9 in the same cycle -> x9 SHALL stay busy and busy_cnt SHALL stay 1.
REQ-036 Issue x2 and write x6=0x55, then pulse rst mid-cycle -> all reads SHALL be 0, busy_cnt SHALL be 0 and rd_busy SHALL be 0 immediately, with no clk edge required.
